// File: rtl/i2c_seq_pkg.sv
// Shared constants and state encodings for the I2C-over-APB job sequencer.
// Register map of the I2C core, its command bytes and the status enable bit.
package i2c_seq_pkg;

   localparam logic [7:0] REG_TX    = 8'h00;
   localparam logic [7:0] REG_RX    = 8'h01;
   localparam logic [7:0] REG_ADDR  = 8'h03;
   localparam logic [7:0] REG_CMD   = 8'h04;
   localparam logic [7:0] REG_PRESC = 8'h05;

   localparam logic [7:0] CMD_START = 8'hC0;
   localparam logic [7:0] CMD_RST   = 8'h00;

   localparam int STAT_EN_BIT = 6;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_TXFILL,
      ST_ADDR,
      ST_PRESC,
      ST_CMD,
      ST_POLL_WAIT,
      ST_POLL,
      ST_RXDRAIN,
      ST_FIN
   } seq_state_e;

   typedef enum logic [1:0] {
      XF_IDLE,
      XF_SETUP,
      XF_ACCESS
   } xfer_state_e;

endpackage

// File: rtl/i2c_apb_xfer.sv
// Single APB transfer engine: a start pulse launches SETUP then ACCESS,
// done_o fires on the ACCESS cycle that sees pready_i.
module i2c_apb_xfer
   import i2c_seq_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] wdata_i,
   input  logic       write_i,
   output logic [7:0] paddr_o,
   output logic       pwrite_o,
   output logic       psel_o,
   output logic       penable_o,
   output logic [7:0] pwdata_o,
   input  logic [7:0] prdata_i,
   input  logic       pready_i,
   output logic [7:0] rdata_o,
   output logic       done_o
);

   xfer_state_e state_q, state_d;
   logic [7:0]  paddr_q, paddr_d;
   logic [7:0]  pwdata_q, pwdata_d;
   logic        pwrite_q, pwrite_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= XF_IDLE;
         paddr_q  <= 8'h00;
         pwdata_q <= 8'h00;
         pwrite_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pwrite_q <= pwrite_d;
      end
   end

   // Address, data and direction are captured at start and held until the next start.
   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pwrite_d = pwrite_q;
      case (state_q)
         XF_IDLE: begin
            if (start_i) begin
               state_d  = XF_SETUP;
               paddr_d  = addr_i;
               pwdata_d = wdata_i;
               pwrite_d = write_i;
            end
         end
         XF_SETUP:  state_d = XF_ACCESS;
         XF_ACCESS: if (pready_i) state_d = XF_IDLE;
         default:   state_d = XF_IDLE;
      endcase
   end

   always_comb begin
      psel_o    = (state_q != XF_IDLE);
      penable_o = (state_q == XF_ACCESS);
      done_o    = (state_q == XF_ACCESS) && pready_i;
      paddr_o   = paddr_q;
      pwdata_o  = pwdata_q;
      pwrite_o  = pwrite_q;
      rdata_o   = prdata_i;
   end

endmodule

// File: rtl/i2c_apb_sequencer.sv
// Runs one I2C job by programming an APB-attached I2C core: TX fill, address,
// prescale, start command, status polling with timeout, then RX drain.
module i2c_apb_sequencer
   import i2c_seq_pkg::*;
#(
   parameter int MAX_LEN  = 8,
   parameter int POLL_GAP = 16,
   parameter int TIMEOUT  = 4096
) (
   input  logic       pclk_i,
   input  logic       preset_ni,
   input  logic       job_valid_i,
   output logic       job_ready_o,
   input  logic       job_rw_i,
   input  logic [6:0] job_addr_i,
   input  logic [3:0] job_len_i,
   input  logic [7:0] job_presc_i,
   input  logic       txd_valid_i,
   output logic       txd_ready_o,
   input  logic [7:0] txd_data_i,
   output logic       rxd_valid_o,
   output logic [7:0] rxd_data_o,
   output logic       done_o,
   output logic       err_o,
   output logic       busy_o,
   output logic [7:0] paddr_o,
   output logic       pwrite_o,
   output logic       psel_o,
   output logic       penable_o,
   output logic [7:0] pwdata_o,
   input  logic [7:0] prdata_i,
   input  logic       pready_i,
   output logic [3:0] state_dbg_o
);

   localparam int             GW         = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GW-1:0]  GAP_LAST   = GW'(POLL_GAP - 1);
   localparam logic [12:0]    POLL_LIMIT = 13'(TIMEOUT);
   localparam logic [3:0]     LEN_MAX    = 4'(MAX_LEN);

   seq_state_e     state_q, state_d;
   logic           rw_q, rw_d;
   logic [6:0]     addr_q, addr_d;
   logic [3:0]     len_q, len_d;
   logic [7:0]     presc_q, presc_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [12:0]    poll_q, poll_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic           err_q, err_d;
   logic           abort_q, abort_d;
   logic           issued_q, issued_d;
   logic           rxd_valid_q, rxd_valid_d;
   logic [7:0]     rxd_data_q, rxd_data_d;

   logic           xfer_start, xfer_write, xfer_done;
   logic [7:0]     xfer_addr, xfer_wdata, xfer_rdata;
   logic [12:0]    poll_inc;

   i2c_apb_xfer u_xfer (
      .clk_i     (pclk_i),
      .rst_ni    (preset_ni),
      .start_i   (xfer_start),
      .addr_i    (xfer_addr),
      .wdata_i   (xfer_wdata),
      .write_i   (xfer_write),
      .paddr_o   (paddr_o),
      .pwrite_o  (pwrite_o),
      .psel_o    (psel_o),
      .penable_o (penable_o),
      .pwdata_o  (pwdata_o),
      .prdata_i  (prdata_i),
      .pready_i  (pready_i),
      .rdata_o   (xfer_rdata),
      .done_o    (xfer_done)
   );

   always_ff @(posedge pclk_i or negedge preset_ni) begin
      if (!preset_ni) begin
         state_q     <= ST_IDLE;
         rw_q        <= 1'b0;
         addr_q      <= 7'h00;
         len_q       <= 4'h0;
         presc_q     <= 8'h00;
         cnt_q       <= 4'h0;
         poll_q      <= 13'h0000;
         gap_q       <= '0;
         err_q       <= 1'b0;
         abort_q     <= 1'b0;
         issued_q    <= 1'b0;
         rxd_valid_q <= 1'b0;
         rxd_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         presc_q     <= presc_d;
         cnt_q       <= cnt_d;
         poll_q      <= poll_d;
         gap_q       <= gap_d;
         err_q       <= err_d;
         abort_q     <= abort_d;
         issued_q    <= issued_d;
         rxd_valid_q <= rxd_valid_d;
         rxd_data_q  <= rxd_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      len_d       = len_q;
      presc_d     = presc_q;
      cnt_d       = cnt_q;
      poll_d      = poll_q;
      gap_d       = gap_q;
      err_d       = err_q;
      abort_d     = abort_q;
      issued_d    = issued_q;
      rxd_valid_d = 1'b0;
      rxd_data_d  = rxd_data_q;
      poll_inc    = (poll_q == 13'h1FFF) ? poll_q : poll_q + 13'd1;

      // issued marks a transfer in flight for the current step of the job.
      if (xfer_start) issued_d = 1'b1;
      if (xfer_done)  issued_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (job_valid_i) begin
               rw_d    = job_rw_i;
               addr_d  = job_addr_i;
               len_d   = job_len_i;
               presc_d = job_presc_i;
               cnt_d   = job_len_i;
               poll_d  = 13'h0000;
               gap_d   = '0;
               abort_d = 1'b0;
               err_d   = 1'b0;
               if (job_len_i == 4'h0 || job_len_i > LEN_MAX) begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  state_d = job_rw_i ? ST_ADDR : ST_TXFILL;
               end
            end
         end
         ST_TXFILL: begin
            if (xfer_done) begin
               cnt_d = cnt_q - 4'h1;
               if (cnt_q == 4'h1) state_d = ST_ADDR;
            end
         end
         ST_ADDR:  if (xfer_done) state_d = ST_PRESC;
         ST_PRESC: if (xfer_done) state_d = ST_CMD;
         ST_CMD: begin
            if (xfer_done) begin
               gap_d   = '0;
               state_d = ST_POLL_WAIT;
            end
         end
         ST_POLL_WAIT: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = ST_POLL;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         ST_POLL: begin
            // Once aborting, the transfer issued here is the core reset write.
            if (xfer_done) begin
               if (abort_q) begin
                  err_d   = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  poll_d = poll_inc;
                  if (!xfer_rdata[STAT_EN_BIT]) begin
                     if (rw_q) begin
                        cnt_d   = len_q;
                        state_d = ST_RXDRAIN;
                     end else begin
                        state_d = ST_FIN;
                     end
                  end else if (poll_inc >= POLL_LIMIT) begin
                     abort_d = 1'b1;
                  end else begin
                     gap_d   = '0;
                     state_d = ST_POLL_WAIT;
                  end
               end
            end
         end
         ST_RXDRAIN: begin
            if (xfer_done) begin
               rxd_valid_d = 1'b1;
               rxd_data_d  = xfer_rdata;
               cnt_d       = cnt_q - 4'h1;
               if (cnt_q == 4'h1) state_d = ST_FIN;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      job_ready_o = (state_q == ST_IDLE);
      busy_o      = (state_q != ST_IDLE);
      done_o      = (state_q == ST_FIN);
      err_o       = (state_q == ST_FIN) && err_q;
      rxd_valid_o = rxd_valid_q;
      rxd_data_o  = rxd_data_q;
      state_dbg_o = state_q;
      txd_ready_o = 1'b0;
      xfer_start  = 1'b0;
      xfer_addr   = REG_TX;
      xfer_wdata  = 8'h00;
      xfer_write  = 1'b1;
      case (state_q)
         ST_TXFILL: begin
            txd_ready_o = !issued_q;
            xfer_start  = !issued_q && txd_valid_i;
            xfer_addr   = REG_TX;
            xfer_wdata  = txd_data_i;
         end
         ST_ADDR: begin
            xfer_start = !issued_q;
            xfer_addr  = REG_ADDR;
            xfer_wdata = {addr_q, rw_q};
         end
         ST_PRESC: begin
            xfer_start = !issued_q;
            xfer_addr  = REG_PRESC;
            xfer_wdata = presc_q;
         end
         ST_CMD: begin
            xfer_start = !issued_q;
            xfer_addr  = REG_CMD;
            xfer_wdata = CMD_START;
         end
         ST_POLL: begin
            xfer_start = !issued_q;
            xfer_addr  = REG_CMD;
            xfer_wdata = CMD_RST;
            xfer_write = abort_q;
         end
         ST_RXDRAIN: begin
            xfer_start = !issued_q;
            xfer_addr  = REG_RX;
            xfer_write = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Bench for i2c_apb_sequencer: an APB slave model of the I2C core logs every
// completed transfer, and each job is compared with the register sequence it should produce.
module tb_i2c_apb_sequencer;

   localparam int MAX_LEN  = 8;
   localparam int POLL_GAP = 4;
   localparam int TIMEOUT  = 8;

   logic       pclk = 1'b0;
   logic       preset_n = 1'b0;
   logic       job_valid = 1'b0, job_ready, job_rw = 1'b0;
   logic [6:0] job_addr = 7'h00;
   logic [3:0] job_len = 4'h0;
   logic [7:0] job_presc = 8'h00;
   logic       txd_valid = 1'b0, txd_ready;
   logic [7:0] txd_data = 8'h00;
   logic       rxd_valid, done, err, busy;
   logic [7:0] rxd_data, paddr, pwdata;
   logic [7:0] prdata = 8'h00;
   logic       pwrite, psel, penable;
   logic       pready = 1'b0;
   logic [3:0] st_dbg;

   int checks = 0;
   int errors = 0;

   // slave model configuration and state
   int   ws = 0;
   int   clear_polls = 0;
   bit   stuck = 1'b0;
   bit   en = 1'b0;
   int   polls_left = 0;
   int   acc_cnt = 0;
   bit   seen_setup = 1'b0;
   logic [7:0] su_addr, su_wdata;
   logic su_write;
   int   stab_err = 0, proto_err = 0;
   int   done_cnt = 0, err_cnt = 0, err_alone = 0;

   logic [16:0] log_q[$];
   logic [16:0] exp_q[$];
   logic [7:0]  rx_src_q[$], got_rx_q[$], exp_rx_q[$], tx_feed_q[$];
   logic [7:0]  tx_b[16];
   logic [7:0]  rx_b[16];
   bit          hs = 1'b0;

   i2c_apb_sequencer #(.MAX_LEN(MAX_LEN), .POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) dut (
      .pclk_i(pclk), .preset_ni(preset_n),
      .job_valid_i(job_valid), .job_ready_o(job_ready), .job_rw_i(job_rw),
      .job_addr_i(job_addr), .job_len_i(job_len), .job_presc_i(job_presc),
      .txd_valid_i(txd_valid), .txd_ready_o(txd_ready), .txd_data_i(txd_data),
      .rxd_valid_o(rxd_valid), .rxd_data_o(rxd_data),
      .done_o(done), .err_o(err), .busy_o(busy),
      .paddr_o(paddr), .pwrite_o(pwrite), .psel_o(psel), .penable_o(penable),
      .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready),
      .state_dbg_o(st_dbg)
   );

   always #5 pclk = ~pclk;

   // APB slave + output monitor, sampled on the falling edge
   initial forever begin
      @(negedge pclk);
      if (!preset_n) begin
         pready = 1'b0; acc_cnt = 0; seen_setup = 1'b0;
      end else if (psel && !penable) begin
         su_addr = paddr; su_wdata = pwdata; su_write = pwrite;
         seen_setup = 1'b1; acc_cnt = 0; pready = 1'b0;
      end else if (psel && penable) begin
         if (!seen_setup) proto_err++;
         if (paddr !== su_addr || pwdata !== su_wdata || pwrite !== su_write) stab_err++;
         if (acc_cnt >= ws) begin
            pready = 1'b1;
            seen_setup = 1'b0;
            if (pwrite) begin
               log_q.push_back({1'b1, paddr, pwdata});
               if (paddr == 8'h04) begin
                  if (pwdata == 8'hC0) begin en = 1'b1; polls_left = clear_polls; end
                  else en = 1'b0;
               end
            end else begin
               prdata = 8'h00;
               if (paddr == 8'h04) begin
                  if (en && !stuck) begin
                     if (polls_left == 0) en = 1'b0;
                     else polls_left--;
                  end
                  prdata = en ? 8'h40 : 8'h00;
               end else if (paddr == 8'h01 && rx_src_q.size() > 0) begin
                  prdata = rx_src_q.pop_front();
               end
               log_q.push_back({1'b0, paddr, prdata});
            end
         end else begin
            pready = 1'b0;
            acc_cnt++;
         end
      end else begin
         pready = 1'b0; seen_setup = 1'b0;
      end
      if (rxd_valid) got_rx_q.push_back(rxd_data);
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (err && !done) err_alone++;
   end

   // write-byte stream feeder
   initial forever begin
      @(negedge pclk);
      if (!preset_n) begin
         hs = 1'b0; txd_valid = 1'b0;
      end else begin
         if (hs && tx_feed_q.size() > 0) tx_feed_q.delete(0);
         txd_valid = (tx_feed_q.size() > 0);
         txd_data  = (tx_feed_q.size() > 0) ? tx_feed_q[0] : 8'h00;
         hs = txd_valid && txd_ready;
      end
   end

   task automatic fill_random();
      for (int i = 0; i < 16; i++) begin
         tx_b[i] = 8'($urandom_range(0, 255));
         rx_b[i] = 8'($urandom_range(0, 255));
      end
   endtask

   // Reference: the register traffic a job must produce on the core.
   task automatic build_exp(input bit rw, input logic [6:0] a, input logic [3:0] l,
                            input logic [7:0] p, input int k, input bit stk);
      exp_q.delete(); exp_rx_q.delete();
      if (l == 0 || l > MAX_LEN) return;
      if (!rw) for (int i = 0; i < l; i++) exp_q.push_back({1'b1, 8'h00, tx_b[i]});
      exp_q.push_back({1'b1, 8'h03, a, rw});
      exp_q.push_back({1'b1, 8'h05, p});
      exp_q.push_back({1'b1, 8'h04, 8'hC0});
      if (stk) begin
         for (int i = 0; i < TIMEOUT; i++) exp_q.push_back({1'b0, 8'h04, 8'h40});
         exp_q.push_back({1'b1, 8'h04, 8'h00});
      end else begin
         for (int i = 0; i < k; i++) exp_q.push_back({1'b0, 8'h04, 8'h40});
         exp_q.push_back({1'b0, 8'h04, 8'h00});
         if (rw) for (int i = 0; i < l; i++) begin
            exp_q.push_back({1'b0, 8'h01, rx_b[i]});
            exp_rx_q.push_back(rx_b[i]);
         end
      end
   endtask

   task automatic clear_logs();
      log_q.delete(); got_rx_q.delete(); tx_feed_q.delete(); rx_src_q.delete();
      done_cnt = 0; err_cnt = 0; err_alone = 0; stab_err = 0; proto_err = 0;
   endtask

   // Drives one job through the handshake and waits (bounded) for its done pulse.
   task automatic run_job(input bit rw, input logic [6:0] a, input logic [3:0] l,
                          input logic [7:0] p, output bit ok);
      bit acc = 1'b0;
      clear_logs();
      if (l != 0 && l <= MAX_LEN) begin
         if (!rw) for (int i = 0; i < l; i++) tx_feed_q.push_back(tx_b[i]);
         else     for (int i = 0; i < l; i++) rx_src_q.push_back(rx_b[i]);
      end
      @(negedge pclk);
      job_valid = 1'b1; job_rw = rw; job_addr = a; job_len = l; job_presc = p;
      for (int n = 0; n < 200 && !acc; n++) begin
         if (job_ready) acc = 1'b1;
         @(negedge pclk);
      end
      job_valid = 1'b0;
      for (int n = 0; n < 4000 && done_cnt == 0; n++) @(negedge pclk);
      repeat (3) @(negedge pclk);
      ok = acc && (done_cnt > 0);
   endtask

   task automatic test_reset();
      preset_n = 1'b0; job_valid = 1'b0;
      repeat (3) @(negedge pclk);
      checks++;
      if ({psel, penable, pwrite, rxd_valid, done, err, busy, txd_ready} !== 8'h00) begin
         errors++; $display("FAIL reset_ctrl got %b want 00000000",
                            {psel, penable, pwrite, rxd_valid, done, err, busy, txd_ready});
      end
      checks++;
      if ({paddr, pwdata} !== 16'h0000) begin
         errors++; $display("FAIL reset_bus got paddr=%h pwdata=%h want 00/00", paddr, pwdata);
      end
      preset_n = 1'b1;
      @(negedge pclk);
      checks++;
      if (psel !== 1'b0) begin errors++; $display("FAIL reset_first_cycle psel got %b want 0", psel); end
      checks++;
      if (job_ready !== 1'b1) begin errors++; $display("FAIL reset_job_ready got %b want 1", job_ready); end
   endtask

   task automatic test_write_fixed();
      bit ok;
      ws = 0; stuck = 1'b0; clear_polls = 2;
      tx_b[0] = 8'h8A; tx_b[1] = 8'h2B; tx_b[2] = 8'hC3;
      build_exp(1'b0, 7'h25, 4'd3, 8'h06, 2, 1'b0);
      run_job(1'b0, 7'h25, 4'd3, 8'h06, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL wr_fixed_done got timeout want done"); end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++; $display("FAIL wr_fixed_len got %0d want %0d", log_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL wr_fixed_xfer%0d got %h want %h", i, log_q[i], exp_q[i]);
         end
      end
      checks++;
      if (done_cnt != 1 || err_cnt != 0) begin
         errors++; $display("FAIL wr_fixed_pulses got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
      end
   endtask

   task automatic test_read_fixed();
      bit ok;
      ws = 0; stuck = 1'b0; clear_polls = 1;
      rx_b[0] = 8'h94; rx_b[1] = 8'hC5; rx_b[2] = 8'h21; rx_b[3] = 8'h84;
      build_exp(1'b1, 7'h34, 4'd4, 8'h11, 1, 1'b0);
      run_job(1'b1, 7'h34, 4'd4, 8'h11, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rd_fixed_done got timeout want done"); end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rd_fixed_len got %0d want %0d", log_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rd_fixed_xfer%0d got %h want %h", i, log_q[i], exp_q[i]);
         end
      end
      checks++;
      if (got_rx_q.size() != 4) begin
         errors++; $display("FAIL rd_fixed_rxcnt got %0d want 4", got_rx_q.size());
      end
      for (int i = 0; i < exp_rx_q.size() && i < got_rx_q.size(); i++) begin
         checks++;
         if (got_rx_q[i] !== exp_rx_q[i]) begin
            errors++; $display("FAIL rd_fixed_rx%0d got %h want %h", i, got_rx_q[i], exp_rx_q[i]);
         end
      end
      checks++;
      if (done_cnt != 1 || err_cnt != 0) begin
         errors++; $display("FAIL rd_fixed_pulses got done=%0d err=%0d want 1/0", done_cnt, err_cnt);
      end
   endtask

   // Random jobs; wait states given by w (negative picks a random count per job).
   task automatic test_random(input int jobs, input int w, input string tag);
      bit ok, rw;
      logic [6:0] a;
      logic [3:0] l;
      logic [7:0] p;
      int k;
      stuck = 1'b0;
      for (int j = 0; j < jobs; j++) begin
         rw = 1'($urandom_range(0, 1));
         a  = 7'($urandom_range(0, 127));
         l  = 4'($urandom_range(1, MAX_LEN));
         p  = 8'($urandom_range(0, 255));
         k  = $urandom_range(0, 3);
         ws = (w < 0) ? $urandom_range(0, 3) : w;
         clear_polls = k;
         fill_random();
         build_exp(rw, a, l, p, k, 1'b0);
         run_job(rw, a, l, p, ok);
         checks++;
         if (!ok || done_cnt != 1 || err_cnt != 0) begin
            errors++; $display("FAIL %s_job%0d_done got ok=%0d done=%0d err=%0d want 1/1/0",
                               tag, j, ok, done_cnt, err_cnt);
         end
         checks++;
         if (log_q.size() != exp_q.size()) begin
            errors++; $display("FAIL %s_job%0d_len got %0d want %0d", tag, j, log_q.size(), exp_q.size());
         end
         for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
               errors++; $display("FAIL %s_job%0d_xfer%0d got %h want %h", tag, j, i, log_q[i], exp_q[i]);
            end
         end
         checks++;
         if (got_rx_q.size() != exp_rx_q.size()) begin
            errors++; $display("FAIL %s_job%0d_rxcnt got %0d want %0d", tag, j, got_rx_q.size(), exp_rx_q.size());
         end
         for (int i = 0; i < exp_rx_q.size() && i < got_rx_q.size(); i++) begin
            checks++;
            if (got_rx_q[i] !== exp_rx_q[i]) begin
               errors++; $display("FAIL %s_job%0d_rx%0d got %h want %h", tag, j, i, got_rx_q[i], exp_rx_q[i]);
            end
         end
         checks++;
         if (stab_err != 0 || proto_err != 0) begin
            errors++; $display("FAIL %s_job%0d_apb got stab=%0d proto=%0d want 0/0", tag, j, stab_err, proto_err);
         end
      end
   endtask

   task automatic test_timeout();
      bit ok;
      ws = 1; stuck = 1'b1; clear_polls = 0;
      fill_random();
      build_exp(1'b0, 7'h51, 4'd2, 8'h03, 0, 1'b1);
      run_job(1'b0, 7'h51, 4'd2, 8'h03, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL timeout_done got timeout want done"); end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++; $display("FAIL timeout_len got %0d want %0d", log_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL timeout_xfer%0d got %h want %h", i, log_q[i], exp_q[i]);
         end
      end
      checks++;
      if (done_cnt != 1 || err_cnt != 1 || err_alone != 0) begin
         errors++; $display("FAIL timeout_pulses got done=%0d err=%0d lone=%0d want 1/1/0",
                            done_cnt, err_cnt, err_alone);
      end
      stuck = 1'b0;
   endtask

   task automatic test_bad_len();
      bit ok, seen, acc;
      int busy_ready;
      ws = 0; clear_polls = 0;
      clear_logs();
      fill_random();
      tx_feed_q.push_back(tx_b[0]); tx_feed_q.push_back(tx_b[1]);
      @(negedge pclk);
      job_valid = 1'b1; job_rw = 1'b0; job_addr = 7'h12; job_len = 4'd0; job_presc = 8'h09;
      @(negedge pclk);
      // first (illegal) job taken; a legal job is now held on the request port
      job_addr = 7'h2C; job_len = 4'd2; job_presc = 8'h44;
      seen = 1'b0; busy_ready = 0;
      for (int n = 0; n < 2 && !seen; n++) begin
         if (done && err) seen = 1'b1;
         if (busy && job_ready) busy_ready++;
         if (!seen) @(negedge pclk);
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL badlen0_pulse got none want done+err within 2"); end
      checks++;
      if (busy_ready != 0 || job_ready !== 1'b0) begin
         errors++; $display("FAIL badlen0_hold got ready=%b while busy want 0", job_ready);
      end
      checks++;
      if (log_q.size() != 0) begin
         errors++; $display("FAIL badlen0_apb got %0d transfers want 0", log_q.size());
      end
      acc = 1'b0;
      for (int n = 0; n < 10 && !acc; n++) begin
         @(negedge pclk);
         if (job_ready) acc = 1'b1;
      end
      @(negedge pclk);
      job_valid = 1'b0;
      checks++;
      if (!acc) begin errors++; $display("FAIL badlen0_second got not accepted want accepted"); end
      build_exp(1'b0, 7'h2C, 4'd2, 8'h44, 0, 1'b0);
      for (int n = 0; n < 2000 && done_cnt < 2; n++) @(negedge pclk);
      repeat (3) @(negedge pclk);
      checks++;
      if (done_cnt != 2 || err_cnt != 1) begin
         errors++; $display("FAIL badlen0_second_pulses got done=%0d err=%0d want 2/1", done_cnt, err_cnt);
      end
      checks++;
      if (log_q.size() != exp_q.size()) begin
         errors++; $display("FAIL badlen0_second_len got %0d want %0d", log_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         checks++;
         if (log_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL badlen0_second_xfer%0d got %h want %h", i, log_q[i], exp_q[i]);
         end
      end
      run_job(1'b1, 7'h0F, 4'(MAX_LEN + 4), 8'h01, ok);
      checks++;
      if (!ok || log_q.size() != 0 || done_cnt != 1 || err_cnt != 1) begin
         errors++; $display("FAIL badlen_big got ok=%0d xfers=%0d done=%0d err=%0d want 1/0/1/1",
                            ok, log_q.size(), done_cnt, err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      bit hit = 1'b0;
      ws = 50; stuck = 1'b0; clear_polls = 0;
      clear_logs();
      fill_random();
      for (int i = 0; i < 3; i++) tx_feed_q.push_back(tx_b[i]);
      @(negedge pclk);
      job_valid = 1'b1; job_rw = 1'b0; job_addr = 7'h33; job_len = 4'd3; job_presc = 8'h02;
      for (int n = 0; n < 100 && !hit; n++) begin
         @(negedge pclk);
         job_valid = 1'b0;
         if (psel && penable && paddr == 8'h00 && pwrite) hit = 1'b1;
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL rstmid_reach got no TXFILL access want access"); end
      #2 preset_n = 1'b0;
      #1;
      checks++;
      if ({psel, penable} !== 2'b00) begin
         errors++; $display("FAIL rstmid_async got psel/penable=%b want 00", {psel, penable});
      end
      checks++;
      if ({pwrite, rxd_valid, done, err, busy, txd_ready} !== 6'h00 || {paddr, pwdata} !== 16'h0000) begin
         errors++; $display("FAIL rstmid_outputs got %b paddr=%h pwdata=%h want 0",
                            {pwrite, rxd_valid, done, err, busy, txd_ready}, paddr, pwdata);
      end
      en = 1'b0;
      repeat (2) @(negedge pclk);
      preset_n = 1'b1;
      @(negedge pclk);
      checks++;
      if (job_ready !== 1'b1 || psel !== 1'b0) begin
         errors++; $display("FAIL rstmid_release got ready=%b psel=%b want 1/0", job_ready, psel);
      end
      test_random(1, 0, "rstmid_next");
   endtask

   initial begin
      #3_000_000;
      $display("FAIL global_watchdog got time limit want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_fixed();
      test_read_fixed();
      test_random(2, 5, "waitstate");
      test_timeout();
      test_bad_len();
      test_reset_mid();
      test_random(6, -1, "random");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
